// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: frame capture, E0/F0 prefix decoding and a FWFT event FIFO.
// Optional build macro PS2_RX_PARITY_CHECK_EN enables rejection of frames with bad odd parity.
module ps2_kbd_rx #(
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic                       clk,
  input  logic                       clrn,
  input  logic                       ps2_clk,
  input  logic                       ps2_data,
  input  logic                       rd_en,
  input  logic                       ovf_clr,
  output logic                       ev_valid,
  output logic [7:0]                 ev_code,
  output logic                       ev_break,
  output logic                       ev_ext,
  output logic [FIFO_DEPTH_LOG2:0]   ev_count,
  output logic                       overflow,
  output logic                       frame_err
);

  localparam int AW    = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
  localparam logic [7:0]  BYTE_EXT = 8'hE0;
  localparam logic [7:0]  BYTE_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } dec_state_e;

`ifdef PS2_RX_PARITY_CHECK_EN
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction
`endif

  // Frame layout in the shift register: [0]=start, [8:1]=data, [9]=parity, [10]=stop.
  function automatic logic frame_ok(input logic [10:0] f);
    logic ok;
    ok = (f[0] == 1'b0) && (f[10] == 1'b1);
`ifdef PS2_RX_PARITY_CHECK_EN
    ok = ok && odd_parity_ok(f[8:1], f[9]);
`endif
    return ok;
  endfunction

  logic [2:0]   sync_q, sync_d;
  logic [3:0]   bit_cnt_q, bit_cnt_d;
  logic [10:0]  shift_q, shift_d;
  logic         frame_done_q, frame_done_d;
  logic         byte_vld_q, byte_vld_d;
  logic [7:0]   byte_q, byte_d;
  logic         frame_err_q, frame_err_d;
  dec_state_e   state_q, state_d;

  logic [9:0]   mem_q [DEPTH];
  logic [9:0]   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]  count_q, count_d;
  logic         valid_q, valid_d;
  logic         ovf_q, ovf_d;

  logic         fall_s;
  logic         push_s;
  logic [9:0]   push_data_s;
  logic         pop_s;
  logic         push_ok_s;
  logic         drop_s;

  // Synchroniser, bit shifter and frame check pipeline.
  always_comb begin
    sync_d       = {sync_q[1:0], ps2_clk};
    fall_s       = (sync_q[2:1] == 2'b10);
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    frame_done_d = 1'b0;
    if (fall_s) begin
      shift_d = {ps2_data, shift_q[10:1]};
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d    = 4'd0;
        frame_done_d = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else begin
      bit_cnt_d = bit_cnt_q;
    end
    frame_err_d = frame_done_q & ~frame_ok(shift_q);
    byte_vld_d  = frame_done_q &  frame_ok(shift_q);
    byte_d      = frame_done_q ? shift_q[8:1] : byte_q;
  end

  // Prefix decoder: E0/F0 only move the state, any other byte emits one event.
  always_comb begin
    state_d     = state_q;
    push_s      = 1'b0;
    push_data_s = {2'b00, byte_q};
    if (byte_vld_q) begin
      if (byte_q == BYTE_EXT) begin
        case (state_q)
          ST_IDLE: state_d = ST_EXT;
          default: state_d = state_q;
        endcase
      end else if (byte_q == BYTE_BRK) begin
        case (state_q)
          ST_IDLE: state_d = ST_BRK;
          ST_EXT:  state_d = ST_EXT_BRK;
          default: state_d = state_q;
        endcase
      end else begin
        push_s      = 1'b1;
        push_data_s = {(state_q == ST_EXT) || (state_q == ST_EXT_BRK),
                       (state_q == ST_BRK) || (state_q == ST_EXT_BRK),
                       byte_q};
        state_d     = ST_IDLE;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Event FIFO; a pop frees the slot so a same-cycle push into a full FIFO is accepted.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    pop_s     = rd_en & valid_q;
    push_ok_s = push_s & ((count_q != FULL_CNT) | pop_s);
    drop_s    = push_s & ~push_ok_s;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = push_data_s;
      wr_ptr_d        = wr_ptr_q + AW'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + {{AW{1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{AW{1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
    valid_d = (count_d != {(AW+1){1'b0}});
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      sync_q       <= 3'b111;
      bit_cnt_q    <= 4'd0;
      shift_q      <= 11'd0;
      frame_done_q <= 1'b0;
      byte_vld_q   <= 1'b0;
      byte_q       <= 8'd0;
      frame_err_q  <= 1'b0;
      state_q      <= ST_IDLE;
      wr_ptr_q     <= {AW{1'b0}};
      rd_ptr_q     <= {AW{1'b0}};
      count_q      <= {(AW+1){1'b0}};
      valid_q      <= 1'b0;
      ovf_q        <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 10'd0;
      end
    end else begin
      sync_q       <= sync_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      frame_done_q <= frame_done_d;
      byte_vld_q   <= byte_vld_d;
      byte_q       <= byte_d;
      frame_err_q  <= frame_err_d;
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      valid_q      <= valid_d;
      ovf_q        <= ovf_d;
      mem_q        <= mem_d;
    end
  end

  assign ev_valid  = valid_q;
  assign ev_code   = mem_q[rd_ptr_q][7:0];
  assign ev_break  = mem_q[rd_ptr_q][8];
  assign ev_ext    = mem_q[rd_ptr_q][9];
  assign ev_count  = count_q;
  assign overflow  = ovf_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed self-checking bench for ps2_kbd_rx (default depth 8).
module tb_ps2_kbd_rx;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd_en = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       ev_valid;
  logic [7:0] ev_code;
  logic       ev_break;
  logic       ev_ext;
  logic [3:0] ev_count;
  logic       overflow;
  logic       frame_err;

  int n_vec = 0;
  int n_err = 0;
  int ferr_seen = 0;
  int win_min = 0;

  ps2_kbd_rx #(.FIFO_DEPTH_LOG2(3)) dut (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rd_en(rd_en), .ovf_clr(ovf_clr), .ev_valid(ev_valid), .ev_code(ev_code),
    .ev_break(ev_break), .ev_ext(ev_ext), .ev_count(ev_count),
    .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_err === 1'b1) ferr_seen <= ferr_seen + 1;
  end

  function automatic logic [10:0] mk_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop);
    logic par;
    par = ~(^code) ^ bad_par;
    return {~bad_stop, par, code, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int nbits, input bit pop_on_last);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk) ps2_data = f[i];
      repeat (4) @(negedge clk);
      ps2_clk = 1'b0;
      if (pop_on_last && (i == nbits - 1)) begin
        repeat (4) @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk) rd_en = 1'b0;
        win_min = ev_count;
        for (int k = 0; k < 2; k++) begin
          @(negedge clk);
          if (ev_count < win_min) win_min = ev_count;
        end
      end else begin
        repeat (6) @(negedge clk);
      end
      ps2_clk = 1'b1;
      repeat (6) @(negedge clk);
    end
    ps2_data = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] code);
    send_bits(mk_frame(code, 1'b0, 1'b0), 11, 1'b0);
  endtask

  task automatic pop_one();
    @(negedge clk) rd_en = 1'b1;
    @(negedge clk) rd_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk) clrn = 1'b0;
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({ev_valid, ev_count, overflow, frame_err} !== 7'b0) begin
      n_err++;
      $display("FAIL reset: valid/count/ovf/ferr = %b/%0d/%b/%b, required 0/0/0/0", ev_valid, ev_count, overflow, frame_err);
    end
    clrn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_make();
    send_byte(8'h1C);
    n_vec++;
    if ({ev_valid, ev_count, ev_code, ev_break, ev_ext} !== {1'b1, 4'd1, 8'h1C, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL make_1c: v=%b cnt=%0d code=%h brk=%b ext=%b, required v=1 cnt=1 code=1c brk=0 ext=0", ev_valid, ev_count, ev_code, ev_break, ev_ext);
    end
    pop_one();
    n_vec++;
    if ({ev_valid, ev_count} !== {1'b0, 4'd0}) begin
      n_err++;
      $display("FAIL make_pop: v=%b cnt=%0d, required v=0 cnt=0", ev_valid, ev_count);
    end
  endtask

  task automatic test_prefix();
    send_byte(8'hF0);
    n_vec++;
    if (ev_count !== 4'd0) begin
      n_err++;
      $display("FAIL prefix_no_event: cnt=%0d, required 0", ev_count);
    end
    send_byte(8'h1C);
    n_vec++;
    if ({ev_count, ev_code, ev_break, ev_ext} !== {4'd1, 8'h1C, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL break_1c: cnt=%0d code=%h brk=%b ext=%b, required cnt=1 code=1c brk=1 ext=0", ev_count, ev_code, ev_break, ev_ext);
    end
    pop_one();
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    n_vec++;
    if ({ev_count, ev_code, ev_break, ev_ext} !== {4'd1, 8'h75, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL ext_break_75: cnt=%0d code=%h brk=%b ext=%b, required cnt=1 code=75 brk=1 ext=1", ev_count, ev_code, ev_break, ev_ext);
    end
    pop_one();
  endtask

  task automatic test_overflow();
    logic [7:0] exp;
    do_reset();
    for (int i = 0; i < 9; i++) send_byte(8'h10 + 8'(i));
    n_vec++;
    if ({ev_count, overflow, ev_code} !== {4'd8, 1'b1, 8'h10}) begin
      n_err++;
      $display("FAIL ovf_fill: cnt=%0d ovf=%b head=%h, required cnt=8 ovf=1 head=10", ev_count, overflow, ev_code);
    end
    @(negedge clk) ovf_clr = 1'b1;
    @(negedge clk) ovf_clr = 1'b0;
    n_vec++;
    if (overflow !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_clr: ovf=%b, required 0", overflow);
    end
    send_bits(mk_frame(8'h19, 1'b0, 1'b0), 11, 1'b1);
    n_vec++;
    if ((win_min != 8) || (ev_count !== 4'd8) || (overflow !== 1'b0)) begin
      n_err++;
      $display("FAIL full_push_pop: min_cnt=%0d cnt=%0d ovf=%b, required 8/8/0", win_min, ev_count, overflow);
    end
    for (int k = 0; k < 8; k++) begin
      exp = (k < 7) ? (8'h11 + 8'(k)) : 8'h19;
      n_vec++;
      if ((ev_valid !== 1'b1) || (ev_code !== exp)) begin
        n_err++;
        $display("FAIL drain_%0d: v=%b code=%h, required v=1 code=%h", k, ev_valid, ev_code, exp);
      end
      pop_one();
    end
    pop_one();
    n_vec++;
    if ({ev_valid, ev_count, overflow} !== {1'b0, 4'd0, 1'b0}) begin
      n_err++;
      $display("FAIL pop_empty: v=%b cnt=%0d ovf=%b, required 0/0/0", ev_valid, ev_count, overflow);
    end
  endtask

  task automatic test_parity();
    int f0;
    f0 = ferr_seen;
    send_bits(mk_frame(8'h1C, 1'b1, 1'b0), 11, 1'b0);
    n_vec++;
`ifdef PS2_RX_PARITY_CHECK_EN
    if ((ferr_seen - f0 != 1) || (ev_count !== 4'd0)) begin
      n_err++;
      $display("FAIL bad_parity: pulses=%0d cnt=%0d, required pulses=1 cnt=0", ferr_seen - f0, ev_count);
    end
`else
    if ((ferr_seen - f0 != 0) || (ev_count !== 4'd1) || (ev_code !== 8'h1C)) begin
      n_err++;
      $display("FAIL bad_parity: pulses=%0d cnt=%0d code=%h, required pulses=0 cnt=1 code=1c", ferr_seen - f0, ev_count, ev_code);
    end
    pop_one();
`endif
  endtask

  task automatic test_bad_stop();
    int f0;
    f0 = ferr_seen;
    send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 11, 1'b0);
    n_vec++;
    if ((ferr_seen - f0 != 1) || (ev_count !== 4'd0)) begin
      n_err++;
      $display("FAIL bad_stop: pulses=%0d cnt=%0d, required pulses=1 cnt=0", ferr_seen - f0, ev_count);
    end
    send_byte(8'hE0);
    send_byte(8'h6B);
    n_vec++;
    if ({ev_count, ev_code, ev_break, ev_ext} !== {4'd1, 8'h6B, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL after_bad_stop: cnt=%0d code=%h brk=%b ext=%b, required cnt=1 code=6b brk=0 ext=1", ev_count, ev_code, ev_break, ev_ext);
    end
    pop_one();
  endtask

  task automatic test_reset_midframe();
    int f0;
    send_bits(mk_frame(8'hA5, 1'b0, 1'b0), 6, 1'b0);
    do_reset();
    f0 = ferr_seen;
    send_byte(8'h1B);
    n_vec++;
    if ((ferr_seen - f0 != 0) || ({ev_count, ev_code, ev_break, ev_ext} !== {4'd1, 8'h1B, 1'b0, 1'b0})) begin
      n_err++;
      $display("FAIL reset_midframe: pulses=%0d cnt=%0d code=%h, required pulses=0 cnt=1 code=1b", ferr_seen - f0, ev_count, ev_code);
    end
    pop_one();
  endtask

  task automatic test_back_to_back();
    logic [7:0] codes [3];
    codes[0] = 8'h2A; codes[1] = 8'h2B; codes[2] = 8'h2C;
    for (int i = 0; i < 3; i++) send_byte(codes[i]);
    n_vec++;
    if (ev_count !== 4'd3) begin
      n_err++;
      $display("FAIL b2b_count: cnt=%0d, required 3", ev_count);
    end
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (ev_code !== codes[i]) begin
        n_err++;
        $display("FAIL b2b_order_%0d: code=%h, required %h", i, ev_code, codes[i]);
      end
      pop_one();
    end
  endtask

  initial begin
    test_reset();
    test_make();
    test_prefix();
    test_overflow();
    test_parity();
    test_bad_stop();
    test_reset_midframe();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_rx.md
PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH_LOG2, default 3, log2 of event FIFO depth (depth = 2**FIFO_DEPTH_LOG2, legal 1..6).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on posedge clk.
REQ-003 SHALL have port clrn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ps2_clk  input  1  raw PS/2 clock from keyboard, asynchronous to clk.
REQ-005 SHALL have port ps2_data  input  1  raw PS/2 data line.
REQ-006 SHALL have port rd_en  input  1  pop head event when high and ev_valid high.
REQ-007 SHALL have port ovf_clr  input  1  clear sticky overflow.
REQ-008 SHALL have port ev_valid  output  1  FIFO non-empty.
REQ-009 SHALL have port ev_code  output  8  head event scan code.
REQ-010 SHALL have port ev_break  output  1  head event is a key release (F0-prefixed).
REQ-011 SHALL have port ev_ext  output  1  head event is extended (E0-prefixed).
REQ-012 SHALL have port ev_count  output  FIFO_DEPTH_LOG2+1  events currently stored.
REQ-013 SHALL have port overflow  output  1  sticky: event dropped because FIFO full.
REQ-014 SHALL have port frame_err  output  1  one-cycle pulse on rejected frame.

Function
REQ-015 SHALL synchronise ps2_clk through 3 flops; a PS/2 falling edge is sync[2:1]==2'b10; ps2_data sampled on that cycle.
REQ-016 SHALL shift 11 bits per frame LSB-first: start, 8 data, odd parity, stop; 4-bit bit counter 0..10, wraps to 0 after bit 10.
REQ-017 SHALL check frame on the cycle after bit 10: start==0, stop==1 (parity per REQ-027); on failure pulse frame_err one cycle, discard byte, leave decoder state unchanged.
REQ-018 Decoder FSM states IDLE, BRK, EXT, EXT_BRK; byte E0: IDLE->EXT; byte F0: IDLE->BRK, EXT->EXT_BRK; no event pushed for prefix bytes.
REQ-019 Any other byte SHALL push {ext,brk,code} (ext=1 in EXT/EXT_BRK, brk=1 in BRK/EXT_BRK) and return to IDLE; push one cycle after frame check.
REQ-020 Redundant prefix (E0 in EXT, F0 in BRK/EXT_BRK) SHALL keep current state.
REQ-021 FIFO SHALL be first-word-fall-through: ev_code/ev_break/ev_ext show head whenever ev_valid=1; values undefined-but-stable when empty.
REQ-022 rd_en with ev_valid=0 SHALL be ignored; pointers wrap modulo depth.
REQ-023 Simultaneous push and pop when full SHALL succeed, ev_count unchanged, no overflow.
REQ-024 Push when full without pop SHALL drop the new event, keep stored events, set overflow.
REQ-025 ovf_clr SHALL clear overflow next cycle; set by a concurrent drop takes priority.

Reset
REQ-026 clrn low SHALL immediately clear: synchroniser to 3'b111, bit counter 0, FSM IDLE, FIFO pointers/ev_count 0, ev_valid 0, overflow 0, frame_err 0; partial frame discarded; reception resumes at next start bit after release.

Configuration
REQ-027 Macro PS2_RX_PARITY_CHECK_EN: defined -> frame with even parity over data+parity bit rejected per REQ-017; undefined -> parity bit ignored, only start/stop checked.

Verification
REQ-028 Send 1C -> one event code=1C break=0 ext=0, ev_count=1; rd_en -> ev_valid=0.
REQ-029 Send F0,1C -> exactly one event code=1C break=1 ext=0; send E0,F0,75 -> code=75 break=1 ext=1.
REQ-030 Depth 8, send 9 make codes 10..18 without reading -> ev_count=8, overflow=1, pops return 10..17; ovf_clr -> overflow=0.
REQ-031 Frame 1C with wrong parity -> macro defined: frame_err pulse, no event; undefined: event 1C, no pulse.
REQ-032 Frame with stop=0 -> frame_err pulse, no event, following E0,6B yields code=6B ext=1.
REQ-033 Assert clrn after bit 5 of a frame, release, send 1B -> single event 1B, no frame_err.
